sprite_blit_ctrl: RTL and testbench

//  Sequences one generated sprite ROM (pixel index in, 16-bit colour / width / height out) and copies
//  its contents into a framebuffer write port at a requested screen position (x,y).

---
 rtl/sprite_blit_ctrl.sv | 136 +++++++++++++
 tb/tb_sprite_blit_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blit_ctrl.sv
// Copies a sprite from a pixel ROM into the framebuffer at (pos_x, pos_y).
// Two-stage pipeline: stage 0 drives the ROM index, stage 1 holds the write request.
module sprite_blit_ctrl #(
  parameter int                 PIX_W    = 17,
  parameter int                 COLOR_W  = 16,
  parameter int                 DIM_W    = 9,
  parameter int                 X_W      = 10,
  parameter int                 Y_W      = 9,
  parameter int                 SCREEN_W = 320,
  parameter int                 SCREEN_H = 240,
  parameter int                 FB_A_W   = 17,
  parameter logic [COLOR_W-1:0] KEY      = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [X_W-1:0]     pos_x,
  input  logic [Y_W-1:0]     pos_y,
  output logic               busy,
  output logic               done,
  output logic [PIX_W-1:0]   spr_pixel,
  input  logic [COLOR_W-1:0] spr_color,
  input  logic [DIM_W-1:0]   spr_width,
  input  logic [DIM_W-1:0]   spr_height,
  output logic               fb_we,
  output logic [FB_A_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ready
);

  localparam int XS = X_W + 1;
  localparam int YS = Y_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [X_W-1:0]    px;
  logic [Y_W-1:0]    py;
  logic [DIM_W-1:0]  w;
  logic [DIM_W-1:0]  h;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic              s1_valid;

  logic [XS-1:0]     x_next;
  logic [YS-1:0]     y_next;
  logic              in_bounds;
  logic              pix_we;
  logic              last;
  logic              stall;
  logic [FB_A_W-1:0] addr_next;

  // Screen coordinates are one bit wider than the inputs so the sum cannot wrap back on screen.
  always_comb begin
    x_next    = XS'(px) + XS'(col);
    y_next    = YS'(py) + YS'(row);
    in_bounds = (x_next < XS'(SCREEN_W)) && (y_next < YS'(SCREEN_H));
    pix_we    = in_bounds && (spr_color != KEY);
    addr_next = FB_A_W'(y_next) * FB_A_W'(SCREEN_W) + FB_A_W'(x_next);
    last      = (col == w - 1'b1) && (row == h - 1'b1);
    stall     = s1_valid && fb_we && !fb_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      spr_pixel <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      s1_valid  <= 1'b0;
      px        <= '0;
      py        <= '0;
      w         <= '0;
      h         <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            px <= pos_x;
            py <= pos_y;
            w  <= spr_width;
            h  <= spr_height;
            if (spr_width == '0 || spr_height == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              col       <= '0;
              row       <= '0;
              spr_pixel <= '0;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            s1_valid <= 1'b1;
            fb_we    <= pix_we;
            fb_addr  <= addr_next;
            fb_data  <= spr_color;
            if (last) begin
              state <= DRAIN;
            end else begin
              spr_pixel <= spr_pixel + PIX_W'(1);
              if (col == w - 1'b1) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          // Stage 1 empties on this edge, so done lands one cycle after the last write slot.
          if (!stall) begin
            s1_valid <= 1'b0;
            fb_we    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Directed bench for sprite_blit_ctrl: stimulus pushes expected writes/done cycles,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sprite_blit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  pos_x = '0;
  logic [8:0]  pos_y = '0;
  logic        busy;
  logic        done;
  logic [16:0] spr_pixel;
  logic [15:0] spr_color;
  logic [8:0]  spr_width = '0;
  logic [8:0]  spr_height = '0;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_ready = 1'b1;

  logic [15:0] rom [0:15];
  assign spr_color = rom[spr_pixel[3:0]];

  sprite_blit_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .busy       (busy),
    .done       (done),
    .spr_pixel  (spr_pixel),
    .spr_color  (spr_color),
    .spr_width  (spr_width),
    .spr_height (spr_height),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_ready   (fb_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] c;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  t0 = 0;
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: cycle numbers are relative to the start edge (cycle 1 follows it).
  always @(negedge clk) begin : monitor
    int  rel;
    wr_t e;
    rel = cyc - t0 + 1;
    if (fb_we && fb_ready) begin
      if (wq.size() == 0) begin
        check("unexpected_write", int'(fb_addr), -1);
      end else begin
        e = wq.pop_front();
        check("wr_addr", int'(fb_addr), int'(e.addr));
        check("wr_data", int'(fb_data), int'(e.data));
        check("wr_cycle", rel, int'(e.c));
        $display("[TB] write addr=%0d data=%h cycle=%0d", fb_addr, fb_data, rel);
      end
    end
    if (done) begin
      if (dq.size() == 0) check("unexpected_done", rel, -1);
      else                check("done_cycle", rel, dq.pop_front());
      check("busy_in_done", int'(busy), 0);
      $display("[TB] done cycle=%0d", rel);
    end
  end

  task automatic push_wr(input int a, input int idx, input int c);
    wr_t e;
    e.addr = a;
    e.data = 32'(rom[idx]);
    e.c    = c;
    wq.push_back(e);
  endtask

  // Sizes and position are scrambled right after start to confirm they were latched.
  task automatic start_blit(input int x, input int y, input int w, input int h);
    @(negedge clk);
    pos_x      = 10'(x);
    pos_y      = 9'(y);
    spr_width  = 9'(w);
    spr_height = 9'(h);
    start      = 1'b1;
    @(posedge clk);
    #1;
    t0         = cyc;
    start      = 1'b0;
    pos_x      = 10'd5;
    pos_y      = 9'd7;
    spr_width  = 9'd7;
    spr_height = 9'd7;
  endtask

  task automatic finish_case(input string name);
    repeat (25) @(posedge clk);
    #1;
    check(name, wq.size() + dq.size(), 0);
    wq.delete();
    dq.delete();
  endtask

  task automatic expect_case1(input int shift);
    push_wr(0,   0, 2 + shift);
    push_wr(1,   1, 3 + shift);
    push_wr(2,   2, 4 + shift);
    push_wr(320, 3, 5 + shift);
    push_wr(321, 4, 6 + shift);
    push_wr(322, 5, 7 + shift);
    dq.push_back(8 + shift);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i * 16'h0111);

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_fb_we", int'(fb_we), 0);
    check("reset_spr_pixel", int'(spr_pixel), 0);
    check("reset_fb_addr", int'(fb_addr), 0);
    check("reset_fb_data", int'(fb_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Case 1: 3x2 opaque at origin
    expect_case1(0);
    start_blit(0, 0, 3, 2);
    check("c1_busy", int'(busy), 1);
    check("c1_pixel0", int'(spr_pixel), 0);
    finish_case("c1_drained");

    // Case 2: pixel 1 transparent
    rom[1] = 16'hFFFF;
    push_wr(0,   0, 2);
    push_wr(2,   2, 4);
    push_wr(320, 3, 5);
    push_wr(321, 4, 6);
    push_wr(322, 5, 7);
    dq.push_back(8);
    start_blit(0, 0, 3, 2);
    finish_case("c2_drained");
    rom[1] = 16'h1111;

    // Case 3: clipped at bottom-right corner
    push_wr(76798, 0, 2);
    push_wr(76799, 1, 3);
    dq.push_back(6);
    start_blit(318, 239, 4, 1);
    finish_case("c3_drained");

    // Case 4: first write stalled for 3 cycles
    expect_case1(3);
    start_blit(0, 0, 3, 2);
    @(posedge clk);
    #1;
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("c4_hold_we", int'(fb_we), 1);
      check("c4_hold_addr", int'(fb_addr), 0);
      @(posedge clk);
      #1;
    end
    fb_ready = 1'b1;
    finish_case("c4_drained");

    // Case 5: zero-width sprite
    dq.push_back(1);
    start_blit(0, 0, 0, 2);
    check("c5_busy_c1", int'(busy), 0);
    @(posedge clk);
    #1;
    check("c5_busy_c2", int'(busy), 0);
    finish_case("c5_drained");

    // Case 6: reset during cycle 4, then a clean rerun
    push_wr(0, 0, 2);
    push_wr(1, 1, 3);
    start_blit(0, 0, 3, 2);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("c6_rst_fb_we", int'(fb_we), 0);
    check("c6_rst_busy", int'(busy), 0);
    check("c6_rst_done", int'(done), 0);
    check("c6_rst_pixel", int'(spr_pixel), 0);
    check("c6_rst_addr", int'(fb_addr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    finish_case("c6_after_reset");
    expect_case1(0);
    start_blit(0, 0, 3, 2);
    finish_case("c6_rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
